// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the hart's RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int XLEN = 32;

  typedef logic [1:0] mem_size_t;

  localparam mem_size_t SIZE_B = 2'b00;
  localparam mem_size_t SIZE_H = 2'b01;
  localparam mem_size_t SIZE_W = 2'b10;

  typedef enum logic {
    REQ_FETCH,
    REQ_LSU
  } requester_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_BUSY,
    ARB_RESP
  } arb_state_t;

  // Byte count of an access; the unused encoding 11 is a word.
  function automatic logic [2:0] size_to_len(input mem_size_t size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter for the hart's single byte-wide RAM port. It sequences
// fetches (always 4 bytes) and loads/stores (1, 2 or 4 bytes). Read bytes
// are assembled little-endian, and store bytes come out of the latched data.
//
// Handshake: a requester raises req with stable address/data and holds it.
// The arbiter answers with a single-cycle done pulse, and the data port is
// valid in that same cycle. The requester must drop req on the edge that
// ends the done cycle, or the arbiter serves it again.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_BITS = 12
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 fetch_req,
  input  logic [ADDR_BITS-1:0] fetch_addr,
  output logic                 fetch_done,
  output logic [XLEN-1:0]      fetch_data,
  input  logic                 lsu_req,
  input  logic                 lsu_we,
  input  logic [1:0]           lsu_size,
  input  logic [ADDR_BITS-1:0] lsu_addr,
  input  logic [XLEN-1:0]      lsu_wdata,
  output logic                 lsu_done,
  output logic [XLEN-1:0]      lsu_rdata,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic                 mem_we,
  output logic [7:0]           mem_wdata,
  input  logic [7:0]           mem_rdata,
  output arb_state_t           state_dbg
);

  arb_state_t           state_q, state_d;
  requester_t           grant_q, grant_d, last_grant_q;
  logic [ADDR_BITS-1:0] base_q;
  logic                 we_q;
  logic [2:0]           len_q;
  logic [2:0]           idx_q;
  logic [XLEN-1:0]      wdata_q;
  logic [XLEN-1:0]      asm_q;
  logic [1:0]           cap_lane;

  assign state_dbg = state_q;
  // RAM data arrives a cycle late, so the byte seen at idx belongs to idx-1.
  assign cap_lane  = 2'(idx_q - 3'd1);

  // Next state, grant choice, and a memory-port decode built from registers only.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    mem_addr  = '0;
    mem_we    = 1'b0;
    mem_wdata = 8'h00;
    case (state_q)
      ARB_IDLE: begin
        if (fetch_req || lsu_req) begin
          state_d = ARB_BUSY;
          if (fetch_req && lsu_req)
            grant_d = (last_grant_q == REQ_FETCH) ? REQ_LSU : REQ_FETCH;
          else if (lsu_req)
            grant_d = REQ_LSU;
          else
            grant_d = REQ_FETCH;
        end
      end
      ARB_BUSY: begin
        if (idx_q < len_q) begin
          mem_addr = base_q + ADDR_BITS'(idx_q);
          mem_we   = we_q;
          if (we_q)
            mem_wdata = wdata_q[{idx_q[1:0], 3'b000} +: 8];
        end
        // A store finishes on its last write; a read needs one extra cycle to capture the final byte.
        if (we_q ? (idx_q == len_q - 3'd1) : (idx_q == len_q))
          state_d = ARB_RESP;
      end
      ARB_RESP: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  // State register, transaction latches, byte assembly and registered done/data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      grant_q      <= REQ_FETCH;
      last_grant_q <= REQ_FETCH;
      base_q       <= '0;
      we_q         <= 1'b0;
      len_q        <= 3'd0;
      idx_q        <= 3'd0;
      wdata_q      <= '0;
      asm_q        <= '0;
      fetch_done   <= 1'b0;
      fetch_data   <= '0;
      lsu_done     <= 1'b0;
      lsu_rdata    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_done <= 1'b0;
      lsu_done   <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          if (state_d == ARB_BUSY) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            base_q       <= (grant_d == REQ_FETCH) ? fetch_addr : lsu_addr;
            we_q         <= (grant_d == REQ_LSU) && lsu_we;
            len_q        <= (grant_d == REQ_FETCH) ? 3'd4 : size_to_len(lsu_size);
            wdata_q      <= lsu_wdata;
            asm_q        <= '0;
            idx_q        <= 3'd0;
          end
        end
        ARB_BUSY: begin
          if (!we_q && idx_q != 3'd0)
            asm_q[{cap_lane, 3'b000} +: 8] <= mem_rdata;
          idx_q <= idx_q + 3'd1;
        end
        ARB_RESP: begin
          if (grant_q == REQ_FETCH) begin
            fetch_done <= 1'b1;
            fetch_data <= asm_q;
          end else begin
            lsu_done  <= 1'b1;
            lsu_rdata <= asm_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a synchronous byte RAM, a transaction-level
// memory model, a vector table, hand-written corner sequences and random traffic.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int AB = 12;

  // clock/reset block
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic            fetch_req = 0, lsu_req = 0, lsu_we = 0;
  logic [AB-1:0]   fetch_addr = '0, lsu_addr = '0;
  logic [1:0]      lsu_size = '0;
  logic [31:0]     lsu_wdata = '0;
  logic            fetch_done, lsu_done, mem_we;
  logic [31:0]     fetch_data, lsu_rdata;
  logic [AB-1:0]   mem_addr;
  logic [7:0]      mem_wdata, mem_rdata;
  arb_state_t      state_dbg;

  mem_port_arbiter #(.ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_done(fetch_done), .fetch_data(fetch_data),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_size(lsu_size),
    .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .lsu_done(lsu_done), .lsu_rdata(lsu_rdata),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .state_dbg(state_dbg)
  );

  // RAM the arbiter drives: synchronous read, write on the edge
  logic [7:0] ram [1<<AB];
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  // reference model: byte array updated per transaction, plus last-grant memory
  logic [7:0] model_mem [1<<AB];
  bit         model_last_lsu;

  int checks = 0;
  int errors = 0;

  logic [19:0]   exp_q[$];
  logic [19:0]   wr_log[$];
  logic [AB-1:0] addr_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int len_of(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [AB-1:0] a, input int n);
    logic [31:0]   d = 0;
    logic [AB-1:0] p;
    for (int i = 0; i < n; i++) begin
      p = a + AB'(i);
      d = d | (32'(model_mem[p]) << (8 * i));
    end
    return d;
  endfunction

  task automatic model_store(input logic [AB-1:0] a, input int n, input logic [31:0] d);
    logic [AB-1:0] p;
    for (int i = 0; i < n; i++) begin
      p = a + AB'(i);
      model_mem[p] = d[8*i +: 8];
      exp_q.push_back({p, d[8*i +: 8]});
    end
  endtask

  task automatic poke(input logic [AB-1:0] a, input logic [7:0] b);
    ram[a] = b;
    model_mem[a] = b;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 0;
    model_last_lsu = 0;
  endtask

  // driver: one request, returns data and edges from sampling edge to done
  task automatic run_txn(input bit is_fetch, input bit we, input logic [1:0] size,
                         input logic [AB-1:0] addr, input logic [31:0] wdata,
                         output logic [31:0] data, output int lat);
    bit seen;
    addr_log.delete();
    wr_log.delete();
    data = '0;
    lat  = -1;
    if (is_fetch) begin
      fetch_req = 1; fetch_addr = addr;
    end else begin
      lsu_req = 1; lsu_we = we; lsu_size = size; lsu_addr = addr; lsu_wdata = wdata;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      @(negedge clock);
      addr_log.push_back(mem_addr);
      if (mem_we) wr_log.push_back({mem_addr, mem_wdata});
      seen = is_fetch ? fetch_done : lsu_done;
      if (seen) begin
        data = is_fetch ? fetch_data : lsu_rdata;
        lat  = k - 1;
        break;
      end
    end
    fetch_req = 0;
    lsu_req   = 0;
    model_last_lsu = !is_fetch;
    if (lat < 0) begin
      check("txn_timeout", 64'(lat), 64'd0);
    end else begin
      @(negedge clock);
      check("done_single_pulse", {62'd0, fetch_done, lsu_done}, 64'd0);
    end
  endtask

  // scoreboard for store byte writes
  task automatic check_writes(input string name);
    check({name, "_wr_count"}, 64'(wr_log.size()), 64'(exp_q.size()));
    while (exp_q.size() > 0 && wr_log.size() > 0)
      check({name, "_wr_byte"}, 64'(wr_log.pop_front()), 64'(exp_q.pop_front()));
    exp_q.delete();
  endtask

  typedef struct {
    bit          is_fetch;
    bit          we;
    logic [1:0]  size;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_lat;
  } vec_t;

  vec_t tbl[10];

  // tie sequence: both requests together, record completion order
  task automatic tie_seq(input string name);
    int          order[$];
    bit          exp_first_lsu;
    logic [31:0] exp_f, exp_l;
    exp_first_lsu = !model_last_lsu;
    exp_f = model_load(12'h000, 4);
    exp_l = model_load(12'h012, 1);
    fetch_addr = 12'h000;
    lsu_we = 0; lsu_size = SIZE_B; lsu_addr = 12'h012; lsu_wdata = '0;
    fetch_req = 1;
    lsu_req   = 1;
    for (int k = 0; k < 60 && order.size() < 2; k++) begin
      @(negedge clock);
      if (lsu_done) begin
        order.push_back(1);
        check({name, "_lsu_data"}, 64'(lsu_rdata), 64'(exp_l));
        lsu_req = 0;
      end
      if (fetch_done) begin
        order.push_back(0);
        check({name, "_fetch_data"}, 64'(fetch_data), 64'(exp_f));
        fetch_req = 0;
      end
    end
    fetch_req = 0;
    lsu_req   = 0;
    check({name, "_both_done"}, 64'(order.size()), 64'd2);
    if (order.size() == 2) begin
      check({name, "_first"}, 64'(order[0]), 64'(exp_first_lsu));
      check({name, "_second"}, 64'(order[1]), 64'(!exp_first_lsu));
      model_last_lsu = (order[1] == 1);
    end
    @(negedge clock);
  endtask

  logic [31:0] got;
  int          lat;

  initial begin
    bit          is_f, we;
    logic [1:0]  sz;
    logic [11:0] a;
    logic [31:0] wd;
    int          n, bad;
    logic [AB-1:0] p;

    for (int i = 0; i < (1 << AB); i++) poke(AB'(i), 8'($urandom));
    poke(12'h000, 8'h93); poke(12'h001, 8'h07); poke(12'h002, 8'h50); poke(12'h003, 8'h00);

    do_reset();
    check("rst_state", 64'(state_dbg), 64'(ARB_IDLE));
    check("rst_fetch_done", 64'(fetch_done), 64'd0);
    check("rst_lsu_done", 64'(lsu_done), 64'd0);
    check("rst_fetch_data", 64'(fetch_data), 64'd0);
    check("rst_lsu_rdata", 64'(lsu_rdata), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'd0);

    tbl[0] = '{1, 0, 2'b10, 12'h000, 32'h0,        32'h00500793, 6};
    tbl[1] = '{0, 1, 2'b10, 12'h010, 32'hDEADBEEF, 32'h0,        5};
    tbl[2] = '{0, 0, 2'b00, 12'h012, 32'h0,        32'h000000AD, 3};
    tbl[3] = '{0, 1, 2'b00, 12'hFFF, 32'h00000034, 32'h0,        2};
    tbl[4] = '{0, 1, 2'b00, 12'h000, 32'h00000012, 32'h0,        2};
    tbl[5] = '{0, 0, 2'b01, 12'hFFF, 32'h0,        32'h00001234, 4};
    tbl[6] = '{0, 0, 2'b11, 12'h010, 32'h0,        32'hDEADBEEF, 6};
    tbl[7] = '{0, 0, 2'b01, 12'h011, 32'h0,        32'h0000ADBE, 4};
    tbl[8] = '{0, 1, 2'b01, 12'h7FF, 32'hCAFE5678, 32'h0,        3};
    tbl[9] = '{0, 0, 2'b01, 12'h7FF, 32'h0,        32'h00005678, 4};

    for (int t = 0; t < 10; t++) begin
      n = tbl[t].is_fetch ? 4 : len_of(tbl[t].size);
      if (tbl[t].we && !tbl[t].is_fetch) model_store(tbl[t].addr, n, tbl[t].wdata);
      run_txn(tbl[t].is_fetch, tbl[t].we, tbl[t].size, tbl[t].addr, tbl[t].wdata, got, lat);
      check($sformatf("vec%0d_latency", t), 64'(lat), 64'(tbl[t].exp_lat));
      if (tbl[t].we && !tbl[t].is_fetch) begin
        check_writes($sformatf("vec%0d", t));
      end else begin
        check($sformatf("vec%0d_data", t), 64'(got), 64'(tbl[t].exp_data));
        for (int i = 0; i < n && i < addr_log.size(); i++) begin
          p = tbl[t].addr + AB'(i);
          check($sformatf("vec%0d_addr%0d", t, i), 64'(addr_log[i]), 64'(p));
        end
      end
    end

    // alternating tie-break after reset: LSU first, then again LSU first
    do_reset();
    tie_seq("tie1");
    tie_seq("tie2");

    // reset during the second byte of a word store
    poke(12'h020, 8'hAA); poke(12'h021, 8'hAA); poke(12'h022, 8'hAA); poke(12'h023, 8'hAA);
    lsu_we = 1; lsu_size = SIZE_W; lsu_addr = 12'h020; lsu_wdata = 32'h11223344;
    lsu_req = 1;
    @(posedge clock); @(negedge clock);
    check("rstmid_idx0_addr", {52'd0, mem_addr}, 64'h020);
    check("rstmid_idx0_we", 64'(mem_we), 64'd1);
    @(posedge clock); @(negedge clock);
    check("rstmid_idx1_addr", {52'd0, mem_addr}, 64'h021);
    check("rstmid_idx1_wdata", 64'(mem_wdata), 64'h33);
    reset = 1;
    lsu_req = 0;
    @(posedge clock); @(negedge clock);
    check("rstmid_we_low", 64'(mem_we), 64'd0);
    check("rstmid_state", 64'(state_dbg), 64'(ARB_IDLE));
    reset = 0;
    model_last_lsu = 0;
    model_mem[12'h020] = 8'h44;
    model_mem[12'h021] = 8'h33;
    bad = 0;
    repeat (8) begin
      @(negedge clock);
      if (lsu_done || fetch_done || mem_we) bad++;
    end
    check("rstmid_no_done", 64'(bad), 64'd0);
    for (int i = 0; i < 4; i++) begin
      p = 12'h020 + AB'(i);
      check($sformatf("rstmid_ram%0d", i), 64'(ram[p]), 64'(model_mem[p]));
    end
    run_txn(1, 0, 2'b10, 12'h000, 32'h0, got, lat);
    check("post_rst_fetch_data", 64'(got), 64'(model_load(12'h000, 4)));
    check("post_rst_fetch_lat", 64'(lat), 64'd6);

    // random traffic against the model
    for (int r = 0; r < 40; r++) begin
      is_f = ($urandom_range(0, 3) == 0);
      we   = !is_f && $urandom_range(0, 1) == 1;
      sz   = 2'($urandom_range(0, 3));
      a    = 12'($urandom_range(0, (1 << AB) - 1));
      wd   = $urandom;
      n    = is_f ? 4 : len_of(sz);
      if (we) model_store(a, n, wd);
      run_txn(is_f, we, sz, a, wd, got, lat);
      check($sformatf("rnd%0d_latency", r), 64'(lat), 64'(we ? n + 1 : n + 2));
      if (we) check_writes($sformatf("rnd%0d", r));
      else check($sformatf("rnd%0d_data", r), 64'(got), 64'(model_load(a, n)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the hart's single byte-wide RAM port between the instruction-fetch requester and the load/store requester. Each transaction is sequenced as 1, 2 or 4 byte accesses: read bytes are assembled little-endian, and write bytes are split out of the store data. It sits between the hart's fetch/execute control and the RAM, replacing the hart's direct indexing of `ram[]`. This lets the hart move to a multi-cycle fetch/execute flow.

## Interface
- `ADDR_BITS`, 12 — RAM byte-address width; RAM holds 2^ADDR_BITS bytes.
- `XLEN`, from `common.sv` (32) — width of the data buses.

Ports:
- `clock`  in  1  — single clock; all state changes on posedge.
- `reset`  in  1  — synchronous, active-high.
- `fetch_req`  in  1  — fetch request; held until `fetch_done`.
- `fetch_addr`  in  ADDR_BITS  — fetch base byte address.
- `fetch_done`  out  1  — one-cycle completion pulse.
- `fetch_data`  out  XLEN  — fetched word; valid only while `fetch_done`=1.
- `lsu_req`  in  1  — load/store request; held until `lsu_done`.
- `lsu_we`  in  1  — 1 = store, 0 = load.
- `lsu_size`  in  2  — `SIZE_B`=00, `SIZE_H`=01, `SIZE_W`=10; 11 is treated as word.
- `lsu_addr`  in  ADDR_BITS  — load/store base byte address.
- `lsu_wdata`  in  XLEN  — store data; byte i is `[8i+7:8i]`.
- `lsu_done`  out  1  — one-cycle completion pulse.
- `lsu_rdata`  out  XLEN  — load data, zero-extended; valid only while `lsu_done`=1.
- `mem_addr`  out  ADDR_BITS  — RAM byte address.
- `mem_we`  out  1  — RAM write enable.
- `mem_wdata`  out  8  — RAM write byte.
- `mem_rdata`  in  8  — RAM read byte; synchronous, valid the cycle after `mem_addr` is presented.

## Operation
- FSM states: `IDLE`, `BUSY`, `RESP`.
- **IDLE**
  - Samples the requests at each edge.
  - Only one request present: that requester is granted.
  - Both requests present: grant the requester that was not `last_grant`. `last_grant` resets to FETCH, so the first tie goes to the LSU.
  - On grant, latch into registers: base address, we, N (fetch: 4; LSU: 1/2/4 by size), and the store data. Clear the assembly register, set `idx`=0, update `last_grant`, and go to BUSY.
- **BUSY**, for each `idx`:
  - While `idx`<N: drive `mem_addr` = base+`idx` (mod 2^ADDR_BITS, so wrap-around is allowed).
  - Store: drive `mem_we`=1 and `mem_wdata` = latched byte `idx`.
  - Load/fetch: when `idx`≥1, capture `mem_rdata` into assembly byte `idx`-1.
  - Store ends after `idx`=N-1. Load/fetch ends after `idx`=N, a no-access cycle that captures the final byte. Either then goes to RESP.
- **RESP**: pulse the granted requester's done for one cycle, present the assembly register on its data port, then go to IDLE.
- Data output rules:
  - Unassembled upper bytes read 0.
  - Misaligned addresses are legal and are accessed bytewise.
  - Sign extension is the hart's job.
- `mem_addr`, `mem_we` and `mem_wdata` are decoded from registered state only. There is no combinational path from any request input to the memory port.
- In IDLE and RESP: `mem_we`=0 and `mem_addr`=0.
- A request dropped mid-transaction is a protocol violation. The transaction still completes and done still pulses.
- A requester must deassert its request on the edge that ends its done cycle, or it is re-served.

## Timing
- Reset values: state=IDLE, both dones=0, both data outputs=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `last_grant`=FETCH.
- Request sampled at edge 0:
  - Load/fetch: done is high in the cycle after edge N+2. A fetch therefore completes in 6 cycles.
  - Store: done is high in the cycle after edge N+1.
- No back-to-back grants: at least one IDLE cycle separates two transactions.
- Reset mid-transaction:
  - State goes to IDLE at that edge and `mem_we` falls immediately.
  - No done is issued.
  - Bytes already written stay written; there is no rollback.

## Structure
- Add to `common.sv`:
  - `SIZE_B`, `SIZE_H`, `SIZE_W` constants.
  - `mem_size_t` typedef (2 bits).
  - `requester_t` enum `{ REQ_FETCH, REQ_LSU }`.
  - `arb_state_t` enum `{ ARB_IDLE, ARB_BUSY, ARB_RESP }`.
- No sub-module: the two-way arbitration and byte sequencing sit inline in one always_ff plus one always_comb decode.

## Test plan
- Reset; RAM[0..3]=93 07 50 00; fetch_req at 0x000 -> `fetch_done` pulses once, 6 cycles after sampling, with `fetch_data`=0x00500793.
- LSU word store at 0x010, data 0xDEADBEEF -> four `mem_we` cycles at addresses 0x010–0x013 with bytes EF BE AD DE, then `lsu_done`. Follow-up byte load at 0x012 -> `lsu_rdata`=0x000000AD.
- Both requests raised together after reset -> LSU is served first, then fetch. Raising both again -> LSU then fetch again, because the alternation continues.
- Half load at 0xFFF with ADDR_BITS=12, RAM[0xFFF]=34, RAM[0x000]=12 -> addresses 0xFFF then 0x000, and `lsu_rdata`=0x00001234.
- Word store to 0x020, reset asserted during the `idx`=1 cycle -> `mem_we`=0 from the next cycle, no `lsu_done`, only 0x020 and 0x021 written. The next fetch completes normally.
- `lsu_size`=11 load at 0x010 -> behaves as a word load, returning 0xDEADBEEF.
